// File: rtl/fwd_hazard_if.sv
`default_nettype none
// ============================================================================
// fwd_hazard_if : ID-stage hazard inputs and EX/ID forwarding/stall outputs
// Revision      : 1.0
// ============================================================================
interface fwd_hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_branch;
    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              fwd_br_a;
    logic              fwd_br_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_memread, id_branch,
        input  stall, fwd_a, fwd_b, fwd_br_a, fwd_br_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_memread, id_branch,
        output stall, fwd_a, fwd_b, fwd_br_a, fwd_br_b, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// fwd_hazard_ctrl : 5-stage MIPS forwarding selects, hazard stall and a
//                   saturating stall counter. Option macro: ID_BRANCH_FWD_EN.
// Revision        : 1.0
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fwd_hazard_if.slave bus
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [REG_AW-1:0] ex_rd_q, ex_rd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic              ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_rw_q, mem_rw_d, mem_mr_q, mem_mr_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_rw_q, wb_rw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       w_ma_ex, w_mb_ex, w_ma_mem, w_mb_mem;
    logic       w_load_use, w_br_stall, w_stall;
    logic       w_fwd_br_a, w_fwd_br_b;
    logic [1:0] w_fwd_a, w_fwd_b;

    // r0 is hard-wired to zero, so it can never be a producer.
    function automatic logic hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r);
        return (rd != '0) && (rd == r);
    endfunction

    function automatic logic [1:0] sel(input logic [REG_AW-1:0] r);
        if (mem_rw_q && hit(mem_rd_q, r))
            return 2'b10;
        else if (wb_rw_q && hit(wb_rd_q, r))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_ma_ex    = bus.id_valid && bus.id_uses_rs && hit(ex_rd_q,  bus.id_rs);
        w_mb_ex    = bus.id_valid && bus.id_uses_rt && hit(ex_rd_q,  bus.id_rt);
        w_ma_mem   = bus.id_valid && bus.id_uses_rs && hit(mem_rd_q, bus.id_rs);
        w_mb_mem   = bus.id_valid && bus.id_uses_rt && hit(mem_rd_q, bus.id_rt);
        w_load_use = ex_mr_q && (w_ma_ex || w_mb_ex);
`ifdef ID_BRANCH_FWD_EN
        // ALU results in MEM feed the ID comparator; only a load in MEM must wait.
        w_br_stall = bus.id_branch &&
                     ((ex_rw_q && (w_ma_ex || w_mb_ex)) ||
                      (mem_mr_q && (w_ma_mem || w_mb_mem)));
        w_fwd_br_a = bus.id_branch && mem_rw_q && !mem_mr_q && w_ma_mem;
        w_fwd_br_b = bus.id_branch && mem_rw_q && !mem_mr_q && w_mb_mem;
`else
        w_br_stall = bus.id_branch &&
                     ((ex_rw_q  && (w_ma_ex  || w_mb_ex)) ||
                      (mem_rw_q && (w_ma_mem || w_mb_mem)));
        w_fwd_br_a = 1'b0;
        w_fwd_br_b = 1'b0;
`endif
        w_stall = w_load_use || w_br_stall;
        w_fwd_a = sel(ex_rs_q);
        w_fwd_b = sel(ex_rt_q);
    end

    always_comb begin
        mem_rd_d = ex_rd_q;
        mem_rw_d = ex_rw_q;
        mem_mr_d = ex_mr_q;
        wb_rd_d  = mem_rd_q;
        wb_rw_d  = mem_rw_q;
        ex_rd_d  = '0;
        ex_rs_d  = '0;
        ex_rt_d  = '0;
        ex_rw_d  = 1'b0;
        ex_mr_d  = 1'b0;
        if (bus.id_valid && !w_stall) begin
            ex_rd_d = bus.id_rd;
            ex_rs_d = bus.id_rs;
            ex_rt_d = bus.id_rt;
            ex_rw_d = bus.id_regwrite;
            ex_mr_d = bus.id_memread;
        end
        cnt_d = cnt_q;
        if (w_stall && (cnt_q != C_CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rd_q  <= '0;
            ex_rs_q  <= '0;
            ex_rt_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            mem_mr_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ex_rd_q  <= ex_rd_d;
            ex_rs_q  <= ex_rs_d;
            ex_rt_q  <= ex_rt_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            mem_rd_q <= mem_rd_d;
            mem_rw_q <= mem_rw_d;
            mem_mr_q <= mem_mr_d;
            wb_rd_q  <= wb_rd_d;
            wb_rw_q  <= wb_rw_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.fwd_a       = w_fwd_a;
    assign bus.fwd_b       = w_fwd_b;
    assign bus.fwd_br_a    = w_fwd_br_a;
    assign bus.fwd_br_b    = w_fwd_br_b;
    assign bus.stall_count = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fwd_hazard_ctrl : scoreboard bench with an instruction-level pipeline model
// Revision           : 1.0
// ============================================================================
module tb_fwd_hazard_ctrl;
    localparam int CW = 4;  // narrow counter so saturation is reachable
`ifdef ID_BRANCH_FWD_EN
    localparam bit BR_FWD = 1'b1;
`else
    localparam bit BR_FWD = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rd, rs, rt;
        logic       urs, urt, rw, mr, br;
    } ins_t;

    typedef struct packed {
        logic          stall;
        logic [1:0]    fa, fb;
        logic          bra, brb;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_AW(5), .CNT_W(CW)) bus ();
    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Instructions currently occupying EX, MEM, WB in the model.
    ins_t ex_m, mem_m, wb_m, prev_id;
    logic [CW-1:0] cnt_m;
    bit   prev_stall, prev_rst;

    function automatic ins_t mk(bit v, int rd, int rs, int rt, bit urs, bit urt, bit rw, bit mr, bit br);
        ins_t i;
        i.v = v; i.rd = 5'(rd); i.rs = 5'(rs); i.rt = 5'(rt);
        i.urs = urs; i.urt = urt; i.rw = rw; i.mr = mr; i.br = br;
        return i;
    endfunction
    function automatic ins_t alu(int rd, int rs, int rt); return mk(1, rd, rs, rt, 1, 1, 1, 0, 0); endfunction
    function automatic ins_t lw(int rd, int rs);          return mk(1, rd, rs, 0, 1, 0, 1, 1, 0); endfunction
    function automatic ins_t beq(int rs, int rt);         return mk(1, 0, rs, rt, 1, 1, 0, 0, 1); endfunction
    function automatic ins_t nop();                       return mk(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

    function automatic bit reads_a(ins_t c, logic [4:0] r); return c.v && r != 0 && c.urs && c.rs == r; endfunction
    function automatic bit reads_b(ins_t c, logic [4:0] r); return c.v && r != 0 && c.urt && c.rt == r; endfunction
    function automatic bit reads(ins_t c, logic [4:0] r);   return reads_a(c, r) || reads_b(c, r); endfunction

    // Youngest writer of r among MEM/WB supplies the EX operand.
    function automatic logic [1:0] src(logic [4:0] r);
        if (r != 0 && mem_m.rw && mem_m.rd == r) return 2'd2;
        if (r != 0 && wb_m.rw && wb_m.rd == r)   return 2'd1;
        return 2'd0;
    endfunction

    function automatic exp_t expect_for(ins_t id);
        exp_t e;
        bit ld, brs, mem_blocks;
        ld = ex_m.mr && reads(id, ex_m.rd);
        mem_blocks = BR_FWD ? mem_m.mr : mem_m.rw;
        brs = id.br && ((ex_m.rw && reads(id, ex_m.rd)) || (mem_blocks && reads(id, mem_m.rd)));
        e.stall = ld || brs;
        e.fa  = src(ex_m.rs);
        e.fb  = src(ex_m.rt);
        e.bra = BR_FWD && id.br && mem_m.rw && !mem_m.mr && reads_a(id, mem_m.rd);
        e.brb = BR_FWD && id.br && mem_m.rw && !mem_m.mr && reads_b(id, mem_m.rd);
        e.cnt = cnt_m;
        return e;
    endfunction

    task automatic clear_model();
        ex_m = '0; mem_m = '0; wb_m = '0; cnt_m = '0;
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input ins_t id, input bit do_rst, output bit st);
        exp_t e;
        @(posedge clk);
        if (prev_rst) clear_model();
        else begin
            wb_m  = mem_m;
            mem_m = ex_m;
            ex_m  = (prev_id.v && !prev_stall) ? prev_id : '0;
            if (prev_stall && cnt_m != '1) cnt_m = cnt_m + 1'b1;
        end
        #2;
        reset           = do_rst;
        bus.id_valid    = id.v;
        bus.id_rd       = id.rd;
        bus.id_rs       = id.rs;
        bus.id_rt       = id.rt;
        bus.id_uses_rs  = id.urs;
        bus.id_uses_rt  = id.urt;
        bus.id_regwrite = id.rw;
        bus.id_memread  = id.mr;
        bus.id_branch   = id.br;
        if (do_rst) clear_model();
        e = expect_for(id);
        if (do_rst) e = '0;
        exp_q.push_back(e);
        st = e.stall;
        prev_id = id; prev_stall = e.stall; prev_rst = do_rst;
    endtask

    // Present one instruction until it leaves ID.
    task automatic issue(input ins_t p);
        bit st = 1'b1;
        for (int k = 0; k < 5 && st; k++) cycle(p, 1'b0, st);
        if (st) chk("stall_bound", 1, 0);
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) issue(nop());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",       int'(bus.stall),       int'(e.stall));
                chk("fwd_a",       int'(bus.fwd_a),       int'(e.fa));
                chk("fwd_b",       int'(bus.fwd_b),       int'(e.fb));
                chk("fwd_br_a",    int'(bus.fwd_br_a),    int'(e.bra));
                chk("fwd_br_b",    int'(bus.fwd_br_b),    int'(e.brb));
                chk("stall_count", int'(bus.stall_count), int'(e.cnt));
            end
        end
    end

    initial begin : driver
        bit st;
        ins_t r;
        clear_model();
        prev_id = '0; prev_stall = 1'b0; prev_rst = 1'b1;
        cycle(nop(), 1'b1, st);
        cycle(nop(), 1'b1, st);
        // Directed scenarios.
        issue(alu(3, 1, 2)); issue(alu(4, 3, 5)); flush();
        issue(lw(2, 1)); issue(alu(4, 2, 2)); flush();
        issue(mk(1, 0, 1, 0, 1, 0, 1, 1, 0)); issue(alu(4, 0, 0)); flush();
        issue(alu(3, 1, 2)); issue(beq(3, 0)); flush();
        issue(lw(3, 1)); issue(beq(0, 3)); flush();
        // Reset while the load-use stall is up.
        issue(lw(2, 1));
        cycle(alu(4, 2, 2), 1'b0, st);
        if (!st) chk("load_use_setup", 0, 1);
        cycle(alu(4, 2, 2), 1'b1, st);
        cycle(alu(4, 2, 2), 1'b0, st);
        if (st) issue(alu(4, 2, 2));
        flush();
        // Randomised traffic over a small register set to force overlaps.
        for (int n = 0; n < 300; n++) begin
            r = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            issue(r);
        end
        flush();
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
